rat_port_hub: RTL and testbench
===============================

# rat_port_hub

Parametrised I/O port hub between the RAT MCU port bus (PORT_ID, OUT_PORT, IN_PORT, IO_STRB) and board peripherals. Replaces hand-written per-wrapper port decode with N_OUT output registers and N_IN synchronised input channels at consecutive port IDs. Adds per-channel write strobes and an input-change interrupt controller with mask and write-1-to-clear pending bits. Sits in the top-level wrapper, clocked on the MCU clock domain.

## Interface
- N_OUT, 4: number of 8-bit output registers, 1..16
- N_IN, 2: number of 8-bit input channels, 1..8
- OUT_BASE, 8'h40: port ID of output register 0; register i at OUT_BASE+i
- IN_BASE, 8'h20: port ID of input channel 0; channel i at IN_BASE+i
- IRQ_MASK_ID, 8'hF0: interrupt mask register port ID, read/write
- IRQ_STAT_ID, 8'hF1: interrupt pending register port ID, read / write-1-to-clear
- CLK  in  1  MCU clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- PORT_ID  in  8  port address from MCU
- OUT_PORT  in  8  write data from MCU
- IO_STRB  in  1  write strobe from MCU, one cycle per OUT instruction
- IN_PORT  out  8  read data to MCU
- IN_DATA  in  N_IN*8  raw asynchronous input channels; channel i = bits [8i+7:8i]
- OUT_DATA  out  N_OUT*8  output registers; register i = bits [8i+7:8i]
- OUT_WE  out  N_OUT  one-cycle pulse on register i write
- INTR  out  1  interrupt request to MCU, level

## Operation
- ID ranges OUT_BASE..OUT_BASE+N_OUT-1, IN_BASE..IN_BASE+N_IN-1, IRQ_MASK_ID, IRQ_STAT_ID must not overlap; overlap is a configuration error (elaboration-time assertion).
- Write: IO_STRB=1 and PORT_ID=OUT_BASE+i -> OUT_DATA[i] <= OUT_PORT, OUT_WE[i]=1 for exactly that cycle. Writes to unmapped IDs or input IDs ignored.
- Input channel: two-flop synchroniser per bit (sync1, sync2), then prev register (prev <= sync2).
- Read mux (combinational from registers): IN_BASE+i -> sync2 of channel i; OUT_BASE+i -> OUT_DATA[i] (readback); IRQ_MASK_ID -> mask zero-extended; IRQ_STAT_ID -> pending zero-extended; any other ID -> 8'h00.
- Change detect: chg[i] = (sync2[i] != prev[i]) and armed; sets pending[i].
- Arm counter: 2-bit, cleared by RESET, increments to 3 and holds; armed = (count==3). Suppresses spurious pending from synchroniser fill after reset.
- Pending clear: IO_STRB=1, PORT_ID=IRQ_STAT_ID -> pending[i] cleared where OUT_PORT[i]=1. Same-cycle set and clear on one bit: set wins.
- Mask write: IO_STRB=1, PORT_ID=IRQ_MASK_ID -> mask <= OUT_PORT[N_IN-1:0].
- INTR = |(pending & mask), combinational from registers.
- Reset values: OUT_DATA 0, OUT_WE 0, sync1/sync2/prev 0, pending 0, mask 0, arm count 0, INTR 0; IN_PORT reflects reset state (0 for every ID).
- RESET asserted mid-write: reset wins; register not updated, OUT_WE stays 0.

## Timing
- Write latency: OUT_DATA and readback valid after the edge sampling IO_STRB; OUT_WE high for the cycle following that edge only.
- Input latency: IN_DATA change before edge k -> sync2 updated after edge k+1 -> IN_PORT read value valid in cycle after edge k+1.
- Interrupt latency: pending set at edge k+2; INTR high in cycle after edge k+2 if masked-in.
- Unmasking an already-pending bit: INTR high the cycle after the mask write edge.
- Clear: INTR low the cycle after the clearing write edge unless another masked bit pending or new change in same cycle.
- Armed 3 edges after RESET deasserts; changes before that are not latched.

## Configuration
- RAT_PORT_HUB_IRQ_EN defined: arm counter, prev registers, pending, mask, INTR logic as above.
- Undefined: none of that logic built; INTR tied 0; IRQ_MASK_ID and IRQ_STAT_ID treated as unmapped (read 8'h00, writes ignored); output and input paths unchanged.

## Test plan
- Reset, then IO_STRB with PORT_ID=8'h41, OUT_PORT=8'hA5 -> OUT_DATA[15:8]=8'hA5 next cycle, OUT_WE=4'b0010 for one cycle, other registers 0; read 8'h41 returns 8'hA5.
- IN_DATA[7:0]=8'h3C changed at edge k -> IN_PORT with PORT_ID=8'h20 reads 8'h00 before, 8'h3C from cycle after edge k+1; PORT_ID=8'h55 reads 8'h00.
- Mask=8'h02, toggle channel 1 -> pending=8'h02 at edge k+2, INTR=1; write 8'h02 to 8'hF1 -> pending 0, INTR=0 next cycle.
- Channel 0 toggles while mask=0 -> pending=8'h01, INTR=0; write 8'h01 to 8'hF0 -> INTR=1 next cycle.
- Clear write to 8'hF1 with OUT_PORT=8'h01 in the same cycle channel 0 change detected -> pending[0] remains 1.
- IN_DATA=8'hFF held through RESET release -> pending stays 0 after arming; RESET during OUT_PORT write to 8'h40 -> OUT_DATA[7:0]=0, OUT_WE=0.

Source files
------------

// File: rtl/rat_port_hub.sv
// rat_port_hub: RAT MCU port-bus hub. N_OUT write/readback registers at
// OUT_BASE.., N_IN synchronised input channels at IN_BASE.., plus an optional
// input-change interrupt controller (mask + write-1-to-clear pending) that is
// built only when RAT_PORT_HUB_IRQ_EN is defined.

// Per-channel two-flop synchroniser for one 8-bit raw input.
module rat_port_hub_sync (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] sync1;

  // sync1 -> sync2 (dout); both cleared by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      dout  <= '0;
    end else begin
      sync1 <= din;
      dout  <= sync1;
    end
  end
endmodule

module rat_port_hub #(
  parameter int         N_OUT       = 4,
  parameter int         N_IN        = 2,
  parameter logic [7:0] OUT_BASE    = 8'h40,
  parameter logic [7:0] IN_BASE     = 8'h20,
  parameter logic [7:0] IRQ_MASK_ID = 8'hF0,
  parameter logic [7:0] IRQ_STAT_ID = 8'hF1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        PORT_ID,
  input  logic [7:0]        OUT_PORT,
  input  logic              IO_STRB,
  output logic [7:0]        IN_PORT,
  input  logic [N_IN*8-1:0] IN_DATA,
  output logic [N_OUT*8-1:0] OUT_DATA,
  output logic [N_OUT-1:0]  OUT_WE,
  output logic              INTR
);
  // ---- configuration sanity: ID ranges must be distinct ----
  localparam int OB = int'(OUT_BASE);
  localparam int IB = int'(IN_BASE);
  localparam int MI = int'(IRQ_MASK_ID);
  localparam int SI = int'(IRQ_STAT_ID);
  localparam bit BAD_SIZE = (N_OUT < 1) || (N_OUT > 16) || (N_IN < 1) || (N_IN > 8) ||
                            (OB + N_OUT > 256) || (IB + N_IN > 256);
  localparam bit OVL_IO   = (OB <= IB + N_IN - 1) && (IB <= OB + N_OUT - 1);
`ifdef RAT_PORT_HUB_IRQ_EN
  localparam bit OVL_IRQ  = (MI == SI) ||
                            (MI >= OB && MI < OB + N_OUT) || (MI >= IB && MI < IB + N_IN) ||
                            (SI >= OB && SI < OB + N_OUT) || (SI >= IB && SI < IB + N_IN);
`else
  localparam bit OVL_IRQ  = 1'b0;
`endif
  if (BAD_SIZE || OVL_IO || OVL_IRQ) begin : g_cfg_err
    $error("rat_port_hub: invalid size or overlapping port ID map");
  end

  // ---- output registers ----
  logic [N_OUT-1:0][7:0] out_q;
  logic [N_OUT-1:0]      wr_hit;

  // decode which output register (if any) this strobe targets
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_OUT; i++)
      wr_hit[i] = IO_STRB && (PORT_ID == OUT_BASE + 8'(i));
  end

  // register write and one-cycle write pulse; reset overrides a concurrent write
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q  <= '0;
      OUT_WE <= '0;
    end else begin
      OUT_WE <= wr_hit;
      for (int i = 0; i < N_OUT; i++)
        if (wr_hit[i]) out_q[i] <= OUT_PORT;
    end
  end

  assign OUT_DATA = out_q;

  // ---- input channels ----
  logic [N_IN-1:0][7:0] sync2;

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    rat_port_hub_sync u_sync (
      .CLK  (CLK),
      .RESET(RESET),
      .din  (IN_DATA[8*g +: 8]),
      .dout (sync2[g])
    );
  end

`ifdef RAT_PORT_HUB_IRQ_EN
  // ---- input-change interrupt controller ----
  logic [N_IN-1:0][7:0] prev;
  logic [N_IN-1:0]      pend, mask, chg;
  logic [1:0]           arm_cnt;
  logic                 armed;

  // synchroniser fill after reset looks like a change; ignore until armed
  assign armed = (arm_cnt == 2'd3);

  // per-channel change flag
  always_comb begin
    chg = '0;
    for (int i = 0; i < N_IN; i++)
      chg[i] = armed && (sync2[i] != prev[i]);
  end

  // arm counter, edge-detect history, mask and pending (set beats clear)
  always_ff @(posedge CLK) begin
    if (RESET) begin
      arm_cnt <= '0;
      prev    <= '0;
      mask    <= '0;
      pend    <= '0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      prev <= sync2;
      if (IO_STRB && PORT_ID == IRQ_MASK_ID) mask <= OUT_PORT[N_IN-1:0];
      if (IO_STRB && PORT_ID == IRQ_STAT_ID)
        pend <= (pend & ~OUT_PORT[N_IN-1:0]) | chg;
      else
        pend <= pend | chg;
    end
  end

  assign INTR = |(pend & mask);
`else
  assign INTR = 1'b0;
`endif

  // read mux; unmapped IDs return zero
  always_comb begin
    IN_PORT = 8'h00;
    for (int i = 0; i < N_OUT; i++)
      if (PORT_ID == OUT_BASE + 8'(i)) IN_PORT = out_q[i];
    for (int i = 0; i < N_IN; i++)
      if (PORT_ID == IN_BASE + 8'(i)) IN_PORT = sync2[i];
`ifdef RAT_PORT_HUB_IRQ_EN
    if (PORT_ID == IRQ_MASK_ID) IN_PORT[N_IN-1:0] = mask;
    if (PORT_ID == IRQ_STAT_ID) IN_PORT[N_IN-1:0] = pend;
`endif
  end
endmodule

// File: tb/tb_rat_port_hub.sv
// Bench for rat_port_hub: directed scenarios plus randomized bus traffic,
// all checked against a cycle-level behavioural model kept here.
module tb_rat_port_hub;
  localparam int N_OUT = 4;
  localparam int N_IN  = 2;
`ifdef RAT_PORT_HUB_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [7:0] LOWMASK = 8'((1 << N_IN) - 1);

  logic CLK = 1'b0;
  logic RESET, IO_STRB, INTR;
  logic [7:0] PORT_ID, OUT_PORT, IN_PORT;
  logic [N_IN*8-1:0]  IN_DATA;
  logic [N_OUT*8-1:0] OUT_DATA;
  logic [N_OUT-1:0]   OUT_WE;

  always #5 CLK = ~CLK;

  rat_port_hub #(
    .N_OUT(N_OUT), .N_IN(N_IN), .OUT_BASE(8'h40), .IN_BASE(8'h20),
    .IRQ_MASK_ID(8'hF0), .IRQ_STAT_ID(8'hF1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .IN_DATA(IN_DATA),
    .OUT_DATA(OUT_DATA), .OUT_WE(OUT_WE), .INTR(INTR)
  );

  int total = 0;
  int bad   = 0;

  // model: register file, write pulses, history of sampled IN_DATA
  // (h[0] = sample at last edge, h[1] = one edge earlier, ...), edges since reset
  logic [7:0]        out_m [N_OUT];
  logic [N_OUT-1:0]  we_m;
  logic [N_IN*8-1:0] h [4];
  int                live;
  logic [7:0]        pend_m, mask_m;

  // one clock edge: apply the specification's rules to the inputs seen at it
  task automatic step();
    logic [7:0] chg;
    @(posedge CLK);
    we_m = '0;
    if (RESET) begin
      for (int i = 0; i < N_OUT; i++) out_m[i] = 8'h00;
      for (int j = 0; j < 4; j++) h[j] = '0;
      live = 0; pend_m = 8'h00; mask_m = 8'h00;
    end else begin
      chg = 8'h00;
      // a change is visible one edge after the read value moves, only once armed
      for (int c = 0; c < N_IN; c++)
        if (IRQ_EN && live >= 3 && h[1][8*c +: 8] != h[2][8*c +: 8]) chg[c] = 1'b1;
      if (IO_STRB) begin
        for (int i = 0; i < N_OUT; i++)
          if (PORT_ID == 8'h40 + 8'(i)) begin out_m[i] = OUT_PORT; we_m[i] = 1'b1; end
        if (IRQ_EN && PORT_ID == 8'hF0) mask_m = OUT_PORT & LOWMASK;
        if (IRQ_EN && PORT_ID == 8'hF1) pend_m = pend_m & ~OUT_PORT;
      end
      pend_m = pend_m | chg;
      if (live < 100) live++;
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = IN_DATA;
    end
    @(negedge CLK);
  endtask

  function automatic logic [7:0] exp_rd(logic [7:0] id);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < N_OUT; i++) if (id == 8'h40 + 8'(i)) r = out_m[i];
    for (int c = 0; c < N_IN; c++)  if (id == 8'h20 + 8'(c)) r = h[1][8*c +: 8];
    if (IRQ_EN && id == 8'hF0) r = mask_m;
    if (IRQ_EN && id == 8'hF1) r = pend_m;
    return r;
  endfunction

  function automatic logic [N_OUT*8-1:0] exp_out();
    logic [N_OUT*8-1:0] r;
    for (int i = 0; i < N_OUT; i++) r[8*i +: 8] = out_m[i];
    return r;
  endfunction

  function automatic logic exp_intr();
    return |(pend_m & mask_m);
  endfunction

  task automatic test_reset();
    logic [7:0] ids [8] = '{8'h20, 8'h21, 8'h40, 8'h41, 8'h43, 8'hF0, 8'hF1, 8'h55};
    RESET = 1'b1; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00; IN_DATA = '0;
    step(); step();
    total++; if (OUT_DATA !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", OUT_DATA); end
    total++; if (OUT_WE !== '0) begin bad++; $display("FAIL reset_we got=%b exp=0", OUT_WE); end
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b exp=0", INTR); end
    foreach (ids[k]) begin
      PORT_ID = ids[k]; #1;
      total++;
      if (IN_PORT !== 8'h00) begin bad++; $display("FAIL reset_rd id=%h got=%h exp=00", ids[k], IN_PORT); end
    end
  endtask

  task automatic test_write();
    RESET = 1'b0; IO_STRB = 1'b0;
    step(); step(); step(); step();
    IO_STRB = 1'b1; PORT_ID = 8'h41; OUT_PORT = 8'hA5;
    step();
    IO_STRB = 1'b0;
    total++; if (OUT_DATA !== 32'h0000A500) begin bad++; $display("FAIL wr_data got=%h exp=0000a500", OUT_DATA); end
    total++; if (OUT_WE !== 4'b0010) begin bad++; $display("FAIL wr_we got=%b exp=0010", OUT_WE); end
    #1;
    total++; if (IN_PORT !== 8'hA5) begin bad++; $display("FAIL wr_readback got=%h exp=a5", IN_PORT); end
    step();
    total++; if (OUT_WE !== 4'b0000) begin bad++; $display("FAIL wr_we_drop got=%b exp=0000", OUT_WE); end
  endtask

  task automatic test_input();
    PORT_ID = 8'h20; IN_DATA[7:0] = 8'h3C;
    step();  // edge k
    total++; if (IN_PORT !== 8'h00) begin bad++; $display("FAIL in_early got=%h exp=00", IN_PORT); end
    step();  // edge k+1
    total++; if (IN_PORT !== 8'h3C) begin bad++; $display("FAIL in_valid got=%h exp=3c", IN_PORT); end
    PORT_ID = 8'h55; #1;
    total++; if (IN_PORT !== 8'h00) begin bad++; $display("FAIL in_unmapped got=%h exp=00", IN_PORT); end
  endtask

  task automatic test_irq_clear();
    step(); step(); step();
    IO_STRB = 1'b1; PORT_ID = 8'hF1; OUT_PORT = 8'hFF; step();
    PORT_ID = 8'hF0; OUT_PORT = 8'h02; step();
    IO_STRB = 1'b0; PORT_ID = 8'hF1;
    IN_DATA[15:8] = IN_DATA[15:8] ^ 8'h5A;
    step(); step();  // edges k, k+1
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", INTR); end
    step();          // edge k+2
    total++; if (IN_PORT !== (IRQ_EN ? 8'h02 : 8'h00)) begin bad++; $display("FAIL irq_pend got=%h exp=%h", IN_PORT, IRQ_EN ? 8'h02 : 8'h00); end
    total++; if (INTR !== IRQ_EN) begin bad++; $display("FAIL irq_set got=%b exp=%b", INTR, IRQ_EN); end
    IO_STRB = 1'b1; OUT_PORT = 8'h02; step();
    IO_STRB = 1'b0;
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", INTR); end
    total++; if (IN_PORT !== 8'h00) begin bad++; $display("FAIL irq_clr_pend got=%h exp=00", IN_PORT); end
  endtask

  task automatic test_unmask();
    IO_STRB = 1'b1; PORT_ID = 8'hF0; OUT_PORT = 8'h00; step();
    IO_STRB = 1'b0; PORT_ID = 8'hF1;
    IN_DATA[7:0] = IN_DATA[7:0] ^ 8'h81;
    step(); step(); step();
    total++; if (IN_PORT !== (IRQ_EN ? 8'h01 : 8'h00)) begin bad++; $display("FAIL unmask_pend got=%h exp=%h", IN_PORT, IRQ_EN ? 8'h01 : 8'h00); end
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL unmask_masked got=%b exp=0", INTR); end
    IO_STRB = 1'b1; PORT_ID = 8'hF0; OUT_PORT = 8'h01; step();
    IO_STRB = 1'b0;
    total++; if (INTR !== IRQ_EN) begin bad++; $display("FAIL unmask_intr got=%b exp=%b", INTR, IRQ_EN); end
    #1;
    total++; if (IN_PORT !== (IRQ_EN ? 8'h01 : 8'h00)) begin bad++; $display("FAIL mask_rd got=%h exp=%h", IN_PORT, IRQ_EN ? 8'h01 : 8'h00); end
  endtask

  task automatic test_set_wins();
    IO_STRB = 1'b1; PORT_ID = 8'hF1; OUT_PORT = 8'hFF; step();
    IO_STRB = 1'b0;
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL sw_pre got=%b exp=0", INTR); end
    IN_DATA[7:0] = IN_DATA[7:0] ^ 8'h10;
    step(); step();  // edges k, k+1
    IO_STRB = 1'b1; PORT_ID = 8'hF1; OUT_PORT = 8'h01;
    step();          // edge k+2: clear and set together
    IO_STRB = 1'b0;
    total++; if (IN_PORT !== (IRQ_EN ? 8'h01 : 8'h00)) begin bad++; $display("FAIL set_wins got=%h exp=%h", IN_PORT, IRQ_EN ? 8'h01 : 8'h00); end
    total++; if (INTR !== IRQ_EN) begin bad++; $display("FAIL set_wins_intr got=%b exp=%b", INTR, IRQ_EN); end
  endtask

  task automatic test_reset_arm();
    IN_DATA = '1; RESET = 1'b1; IO_STRB = 1'b0; step(); step();
    RESET = 1'b0; PORT_ID = 8'hF1;
    for (int n = 0; n < 6; n++) step();
    total++; if (IN_PORT !== 8'h00) begin bad++; $display("FAIL arm_pend got=%h exp=00", IN_PORT); end
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL arm_intr got=%b exp=0", INTR); end
    IO_STRB = 1'b1; PORT_ID = 8'h40; OUT_PORT = 8'h33; step();
    RESET = 1'b1; OUT_PORT = 8'h77; step();
    RESET = 1'b0; IO_STRB = 1'b0;
    total++; if (OUT_DATA[7:0] !== 8'h00) begin bad++; $display("FAIL rst_wr got=%h exp=00", OUT_DATA[7:0]); end
    total++; if (OUT_WE !== 4'b0000) begin bad++; $display("FAIL rst_wr_we got=%b exp=0000", OUT_WE); end
  endtask

  task automatic test_random();
    logic [7:0] ids [10] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20, 8'h21, 8'hF0, 8'hF1, 8'h3F};
    RESET = 1'b0;
    for (int n = 0; n < 400; n++) begin
      RESET = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) IN_DATA = N_IN*8'($urandom);
      IO_STRB  = ($urandom_range(0, 1) == 1);
      PORT_ID  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ids[$urandom_range(0, 9)];
      OUT_PORT = 8'($urandom);
      step();
      total++; if (OUT_DATA !== exp_out()) begin bad++; $display("FAIL rnd_out n=%0d got=%h exp=%h", n, OUT_DATA, exp_out()); end
      total++; if (OUT_WE !== we_m) begin bad++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, OUT_WE, we_m); end
      total++; if (INTR !== exp_intr()) begin bad++; $display("FAIL rnd_intr n=%0d got=%b exp=%b", n, INTR, exp_intr()); end
      total++; if (IN_PORT !== exp_rd(PORT_ID)) begin bad++; $display("FAIL rnd_rd n=%0d id=%h got=%h exp=%h", n, PORT_ID, IN_PORT, exp_rd(PORT_ID)); end
    end
    RESET = 1'b0; IO_STRB = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_input();
    test_irq_clear();
    test_unmask();
    test_set_wins();
    test_reset_arm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
